// File: rtl/uart_rx_fifo_if.sv
// Bundles the RS232R-facing capture handshake and the CPU-facing read/status signals
// of the receive FIFO. The FIFO itself connects through the slave modport.
interface uart_rx_fifo_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic [DW-1:0] rx_data;
    logic          rx_rdy;
    logic          rx_done;
    logic          pop;
    logic [DW-1:0] dout;
    logic          rdy;
    logic [AW:0]   count;
    logic          ovf;
    logic          clr_ovf;

    modport master (
        output rx_data,
        output rx_rdy,
        input  rx_done,
        output pop,
        input  dout,
        input  rdy,
        input  count,
        input  ovf,
        output clr_ovf
    );

    modport slave (
        input  rx_data,
        input  rx_rdy,
        output rx_done,
        input  pop,
        output dout,
        output rdy,
        output count,
        output ovf,
        input  clr_ovf
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO: drains the RS232R holding register one byte per two cycles
// and presents head data, occupancy and a sticky overflow flag to the CPU inbus mux.
module uart_rx_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input logic           clk_i,
    input logic           rst_ni,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CAP_IDLE,
        CAP_HOLD
    } cap_state_e;

    cap_state_e    state_q, state_d;
    logic          rx_done_q, rx_done_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic drop;
    logic pop_ok;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign pop_ok = bus.pop & ~empty;

    // A pop in the capture cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        state_d   = state_q;
        rx_done_d = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (bus.rx_rdy) begin
                    rx_done_d = 1'b1;
                    state_d   = CAP_HOLD;
                    if (!full || pop_ok) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            CAP_HOLD: begin
                state_d = CAP_IDLE;
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_ok);
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= CAP_IDLE;
            rx_done_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rx_done = rx_done_q;
    assign bus.dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.rdy     = ~empty;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;

    byte unsigned mQ[$];
    bit           mOvf;
    bit           mHold;
    bit           mDone;

    uart_rx_fifo_if #(.AW(4), .DW(8)) bus ();

    uart_rx_fifo #(.AW(4), .DW(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Receiver can only be serviced every other cycle; the byte is taken after any same-cycle pop.
    task automatic modelStep();
        bit cap;
        bit popped;
        bit accepted;
        if (!rst_n) begin
            mQ.delete();
            mOvf  = 1'b0;
            mHold = 1'b0;
            mDone = 1'b0;
        end else begin
            cap      = bus.rx_rdy && !mHold;
            popped   = bus.pop && (mQ.size() != 0);
            accepted = cap && ((mQ.size() < 16) || popped);
            if (popped) void'(mQ.pop_front());
            if (accepted) mQ.push_back(bus.rx_data);
            if (cap && !accepted) mOvf = 1'b1;
            else if (bus.clr_ovf) mOvf = 1'b0;
            mDone = cap;
            mHold = cap;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".dout"}, 32'(bus.dout), (mQ.size() != 0) ? 32'(mQ[0]) : 32'd0);
        checkOutput({tag, ".rdy"}, 32'(bus.rdy), 32'(mQ.size() != 0));
        checkOutput({tag, ".count"}, 32'(bus.count), 32'(mQ.size()));
        checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(mOvf));
        checkOutput({tag, ".rx_done"}, 32'(bus.rx_done), 32'(mDone));
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic [7:0] d,
                                 input logic p, input logic c, input logic rn);
        @(negedge clk);
        bus.rx_rdy  = r;
        bus.rx_data = d;
        bus.pop     = p;
        bus.clr_ovf = c;
        rst_n       = rn;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic pushByte(input string tag, input logic [7:0] d);
        applyStimulus(tag, 1'b1, d, 1'b0, 1'b0, 1'b1);
        applyStimulus(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic popByte(input string tag);
        applyStimulus(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.pop     = 1'b0;
        bus.clr_ovf = 1'b0;
        mHold       = 1'b0;
        mDone       = 1'b0;
        mOvf        = 1'b0;

        doReset("reset");
        checkOutput("reset.count", 32'(bus.count), 32'd0);
        checkOutput("reset.dout", 32'(bus.dout), 32'd0);

        // Three bytes in, three out, FWFT order.
        pushByte("t1", 8'h41);
        pushByte("t1", 8'h42);
        pushByte("t1", 8'h43);
        checkOutput("t1.count3", 32'(bus.count), 32'd3);
        checkOutput("t1.head", 32'(bus.dout), 32'h41);
        popByte("t1");
        checkOutput("t1.pop1", 32'(bus.dout), 32'h42);
        popByte("t1");
        checkOutput("t1.pop2", 32'(bus.dout), 32'h43);
        popByte("t1");
        checkOutput("t1.empty", 32'(bus.dout), 32'h00);
        checkOutput("t1.rdy0", 32'(bus.rdy), 32'd0);

        // Overflow: 17th byte is dropped but still acknowledged.
        for (int i = 0; i < 16; i++) pushByte("t2", 8'(i));
        applyStimulus("t2", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        checkOutput("t2.done_on_drop", 32'(bus.rx_done), 32'd1);
        applyStimulus("t2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t2.count16", 32'(bus.count), 32'd16);
        checkOutput("t2.ovf", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t2.order", 32'(bus.dout), 32'(i));
            popByte("t2");
        end
        checkOutput("t2.drained", 32'(bus.count), 32'd0);
        applyStimulus("t2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Full FIFO with a coinciding pop accepts the new byte without overflow.
        for (int i = 0; i < 16; i++) pushByte("t3", 8'(8'h10 + i));
        applyStimulus("t3", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        applyStimulus("t3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.ovf0", 32'(bus.ovf), 32'd0);
        checkOutput("t3.count16", 32'(bus.count), 32'd16);
        for (int i = 0; i < 15; i++) popByte("t3");
        checkOutput("t3.tail", 32'(bus.dout), 32'h77);
        popByte("t3");

        // Pop while empty is ignored.
        popByte("t4");
        checkOutput("t4.count0", 32'(bus.count), 32'd0);
        pushByte("t4", 8'h55);
        checkOutput("t4.dout55", 32'(bus.dout), 32'h55);
        popByte("t4");

        // Overflow set beats clear; clear alone then works.
        for (int i = 0; i < 16; i++) pushByte("t5", 8'(8'h20 + i));
        pushByte("t5", 8'hE1);
        checkOutput("t5.ovf_set", 32'(bus.ovf), 32'd1);
        applyStimulus("t5", 1'b1, 8'hE2, 1'b0, 1'b1, 1'b1);
        checkOutput("t5.set_wins", 32'(bus.ovf), 32'd1);
        applyStimulus("t5", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("t5.cleared", 32'(bus.ovf), 32'd0);

        // Reset with contents and the capture FSM mid-handshake.
        doReset("t6");
        for (int i = 0; i < 6; i++) pushByte("t6", 8'(8'h30 + i));
        applyStimulus("t6", 1'b1, 8'h36, 1'b0, 1'b0, 1'b1);
        checkOutput("t6.count7", 32'(bus.count), 32'd7);
        applyStimulus("t6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("t6.count0", 32'(bus.count), 32'd0);
        checkOutput("t6.rdy0", 32'(bus.rdy), 32'd0);
        checkOutput("t6.done0", 32'(bus.rx_done), 32'd0);
        checkOutput("t6.ovf0", 32'(bus.ovf), 32'd0);
        applyStimulus("t6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Pointer wrap: many push/pop pairs with random data.
        for (int i = 0; i < 40; i++) begin
            pushByte("wrap", 8'($urandom_range(0, 255)));
            popByte("wrap");
        end

        // Random traffic, including back-to-back rx_rdy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus("rand",
                          1'($urandom_range(0, 99) < 55),
                          8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 99) < 35),
                          1'($urandom_range(0, 99) < 5),
                          1'($urandom_range(0, 199) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
